// File: rtl/time_keeper.sv
// time_keeper: hh:mm:ss timekeeper with selectable tick rate, run/set FSM,
// 12/24-hour display, set-mode blink strobe and hourly chime.
// Ports:
//   clk, RST           clock, asynchronous active-high reset
//   speed_sel[1:0]     tick-rate select (TICK_HZ0..3)
//   key_mode, key_inc  debounced single-cycle key pulses
//   mode_12h           1 = 12-hour display
//   disp_dat_0..5[3:0] BCD digits ss, mm, hh (hours display-converted)
//   set_field[1:0]     0=RUN 1=hours 2=minutes 3=seconds
//   blink              field-blank strobe, 0 in RUN
//   pm                 afternoon flag in 12-hour mode
//   LED                one-cycle hourly chime
module time_keeper #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned TICK_HZ0 = 1,
    parameter int unsigned TICK_HZ1 = 10,
    parameter int unsigned TICK_HZ2 = 100,
    parameter int unsigned TICK_HZ3 = 1000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [1:0] speed_sel,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       mode_12h,
    output logic [3:0] disp_dat_0,
    output logic [3:0] disp_dat_1,
    output logic [3:0] disp_dat_2,
    output logic [3:0] disp_dat_3,
    output logic [3:0] disp_dat_4,
    output logic [3:0] disp_dat_5,
    output logic [1:0] set_field,
    output logic       blink,
    output logic       pm,
    output logic       LED
);

    localparam int unsigned P0    = CLK_FREQ / TICK_HZ0;
    localparam int unsigned P1    = CLK_FREQ / TICK_HZ1;
    localparam int unsigned P2    = CLK_FREQ / TICK_HZ2;
    localparam int unsigned P3    = CLK_FREQ / TICK_HZ3;
    localparam int unsigned P01   = (P0 >= P1) ? P0 : P1;
    localparam int unsigned P23   = (P2 >= P3) ? P2 : P3;
    localparam int unsigned PMAX  = (P01 >= P23) ? P01 : P23;
    localparam int unsigned PRE_W = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int unsigned BLK_HALF = CLK_FREQ / (2 * BLINK_HZ);
    localparam int unsigned BLK_W    = (BLK_HALF > 1) ? $clog2(BLK_HALF) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [PRE_W-1:0]   period_last_c;
    logic [1:0]         speed_q;
    logic               tick_c;
    logic [7:0]         sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic               chime_q, chime_d;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               blk_ph_q, blk_ph_d;
    logic [4:0]         hour_bin_c;
    logic [7:0]         disp_hour_c;
    logic               pm_c;

    // BCD minute/second increment, 59 wraps to 00
    function automatic logic [7:0] inc59(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // BCD hour increment, 23 wraps to 00
    function automatic logic [7:0] inc23(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Prescaler terminal count for the selected rate
    always_comb begin
        period_last_c = '0;
        case (speed_sel)
            2'd0:    period_last_c = PRE_W'(P0 - 1);
            2'd1:    period_last_c = PRE_W'(P1 - 1);
            2'd2:    period_last_c = PRE_W'(P2 - 1);
            default: period_last_c = PRE_W'(P3 - 1);
        endcase
    end

    // Next-state: FSM, prescaler, time counters, chime, blink phase
    always_comb begin
        state_d   = state_q;
        pre_d     = '0;
        tick_c    = 1'b0;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        chime_d   = 1'b0;
        blk_cnt_d = '0;
        blk_ph_d  = 1'b0;

        if (key_mode) begin
            case (state_q)
                ST_RUN:   state_d = ST_SET_H;
                ST_SET_H: state_d = ST_SET_M;
                ST_SET_M: state_d = ST_SET_S;
                default:  state_d = ST_RUN;
            endcase
        end

        // A rate change restarts the period without ticking
        if (state_q == ST_RUN && speed_sel == speed_q) begin
            if (pre_q == period_last_c) begin
                tick_c = 1'b1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        if (tick_c) begin
            sec_d = inc59(sec_q);
            if (sec_q == 8'h59) begin
                min_d = inc59(min_q);
                if (min_q == 8'h59) begin
                    hour_d  = inc23(hour_q);
                    chime_d = 1'b1;
                end
            end
        end else if (key_inc && !key_mode) begin
            case (state_q)
                ST_SET_H: hour_d = inc23(hour_q);
                ST_SET_M: min_d  = inc59(min_q);
                ST_SET_S: sec_d  = inc59(sec_q);
                default:  ;
            endcase
        end

        if (state_q != ST_RUN) begin
            if (blk_cnt_q == BLK_W'(BLK_HALF - 1)) begin
                blk_ph_d = ~blk_ph_q;
            end else begin
                blk_cnt_d = blk_cnt_q + BLK_W'(1);
                blk_ph_d  = blk_ph_q;
            end
        end
    end

    // 24h BCD hour to display hour and pm flag
    always_comb begin
        hour_bin_c  = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
        disp_hour_c = hour_q;
        pm_c        = 1'b0;
        if (mode_12h) begin
            pm_c = (hour_bin_c >= 5'd12);
            if (hour_bin_c == 5'd0) begin
                disp_hour_c = 8'h12;
            end else if (hour_bin_c > 5'd21) begin
                disp_hour_c = {4'd1, 4'(hour_bin_c - 5'd22)};
            end else if (hour_bin_c > 5'd12) begin
                disp_hour_c = {4'd0, 4'(hour_bin_c - 5'd12)};
            end
        end
    end

    // Internal state registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q   <= ST_RUN;
            pre_q     <= '0;
            speed_q   <= 2'd0;
            sec_q     <= 8'h00;
            min_q     <= 8'h00;
            hour_q    <= 8'h00;
            chime_q   <= 1'b0;
            blk_cnt_q <= '0;
            blk_ph_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            speed_q   <= speed_sel;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hour_q    <= hour_d;
            chime_q   <= chime_d;
            blk_cnt_q <= blk_cnt_d;
            blk_ph_q  <= blk_ph_d;
        end
    end

    // Output registers, one cycle behind the internal state
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            disp_dat_0 <= 4'd0;
            disp_dat_1 <= 4'd0;
            disp_dat_2 <= 4'd0;
            disp_dat_3 <= 4'd0;
            disp_dat_4 <= 4'd0;
            disp_dat_5 <= 4'd0;
            set_field  <= 2'd0;
            blink      <= 1'b0;
            pm         <= 1'b0;
            LED        <= 1'b0;
        end else begin
            disp_dat_0 <= sec_q[3:0];
            disp_dat_1 <= sec_q[7:4];
            disp_dat_2 <= min_q[3:0];
            disp_dat_3 <= min_q[7:4];
            disp_dat_4 <= disp_hour_c[3:0];
            disp_dat_5 <= disp_hour_c[7:4];
            set_field  <= 2'(state_q);
            blink      <= blk_ph_q & (state_q != ST_RUN);
            pm         <= pm_c;
            LED        <= chime_q;
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper at CLK_FREQ=1000, ticks 1/10/100/1000 Hz, BLINK_HZ=2.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] speed_sel = 2'd0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic       mode_12h = 1'b0;
    logic [3:0] disp_dat_0, disp_dat_1, disp_dat_2, disp_dat_3, disp_dat_4, disp_dat_5;
    logic [1:0] set_field;
    logic       blink, pm, LED;
    logic [23:0] tm;

    int vectors = 0;
    int miscompares = 0;

    time_keeper #(
        .CLK_FREQ(1000), .TICK_HZ0(1), .TICK_HZ1(10), .TICK_HZ2(100),
        .TICK_HZ3(1000), .BLINK_HZ(2)
    ) dut (
        .clk(clk), .RST(RST), .speed_sel(speed_sel), .key_mode(key_mode),
        .key_inc(key_inc), .mode_12h(mode_12h),
        .disp_dat_0(disp_dat_0), .disp_dat_1(disp_dat_1), .disp_dat_2(disp_dat_2),
        .disp_dat_3(disp_dat_3), .disp_dat_4(disp_dat_4), .disp_dat_5(disp_dat_5),
        .set_field(set_field), .blink(blink), .pm(pm), .LED(LED)
    );

    always #5 clk = ~clk;

    assign tm = {disp_dat_5, disp_dat_4, disp_dat_3, disp_dat_2, disp_dat_1, disp_dat_0};

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_mode();
        key_mode = 1'b1;
        step(1);
        key_mode = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            key_inc = 1'b1;
            step(1);
            key_inc = 1'b0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(2);
        RST = 1'b0;
    endtask

    initial begin
        // 1: reset values, then 1 Hz counting
        step(2);
        check("rst_time", tm, 24'h000000);
        check("rst_field", 24'(set_field), 24'd0);
        check("rst_flags", 24'({blink, pm, LED}), 24'd0);
        RST = 1'b0;
        step(1000);
        check("t1_before_tick", tm, 24'h000000);
        step(1);
        check("t1_first_tick", tm, 24'h000001);
        step(58999);
        check("t1_59s", tm, 24'h000059);
        step(1);
        check("t1_min_carry", tm, 24'h000100);

        // 2: preset 23:59:59 and roll over at the fastest rate
        do_reset();
        pulse_mode();
        pulse_inc(23);
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        speed_sel = 2'd3;
        pulse_inc(59);
        pulse_mode();
        step(1);
        check("t2_preset", tm, 24'h235959);
        check("t2_run_field", 24'(set_field), 24'd0);
        check("t2_led_before", 24'(LED), 24'd0);
        step(1);
        check("t2_rollover", tm, 24'h000000);
        check("t2_led_pulse", 24'(LED), 24'd1);
        step(1);
        check("t2_next_sec", tm, 24'h000001);
        check("t2_led_after", 24'(LED), 24'd0);
        speed_sel = 2'd0;

        // 3: hour set with wrap, no ticks, blink period
        do_reset();
        pulse_mode();
        pulse_inc(25);
        step(1);
        check("t3_hours", tm, 24'h010000);
        check("t3_field", 24'(set_field), 24'd1);
        check("t3_blink_start", 24'(blink), 24'd0);
        step(224);
        check("t3_blink_250", 24'(blink), 24'd0);
        step(1);
        check("t3_blink_on", 24'(blink), 24'd1);
        step(249);
        check("t3_blink_500", 24'(blink), 24'd1);
        step(1);
        check("t3_blink_off", 24'(blink), 24'd0);
        check("t3_no_ticks", tm, 24'h010000);

        // 4: 12/24-hour display conversion
        mode_12h = 1'b1;
        do_reset();
        step(1);
        check("t4_midnight_12h", tm, 24'h120000);
        check("t4_midnight_pm", 24'(pm), 24'd0);
        mode_12h = 1'b0;
        step(1);
        check("t4_midnight_24h", tm, 24'h000000);
        do_reset();
        pulse_mode();
        pulse_inc(13);
        pulse_mode();
        pulse_inc(5);
        pulse_mode();
        pulse_mode();
        step(1);
        check("t4_13_24h", tm, 24'h130500);
        check("t4_13_24h_pm", 24'(pm), 24'd0);
        mode_12h = 1'b1;
        step(1);
        check("t4_13_12h", tm, 24'h010500);
        check("t4_13_12h_pm", 24'(pm), 24'd1);
        pulse_mode();
        pulse_inc(23);
        step(1);
        check("t4_noon_12h", tm, 24'h120500);
        check("t4_noon_pm", 24'(pm), 24'd1);
        mode_12h = 1'b0;

        // 5: key_inc ignored in RUN; key_mode wins over key_inc
        do_reset();
        pulse_inc(1);
        step(1);
        check("t5_inc_in_run", tm, 24'h000000);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        step(1);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        step(1);
        check("t5_field", 24'(set_field), 24'd1);
        check("t5_hours_kept", tm, 24'h000000);
        pulse_inc(1);
        step(1);
        check("t5_inc_set_h", tm, 24'h010000);

        // 6: rate change mid-period, then reset during SET_M
        do_reset();
        step(500);
        speed_sel = 2'd1;
        step(101);
        check("t6_no_early_tick", tm, 24'h000000);
        step(1);
        check("t6_tick_100", tm, 24'h000001);
        speed_sel = 2'd0;
        pulse_mode();
        pulse_mode();
        pulse_inc(3);
        step(1);
        check("t6_set_m", tm, 24'h000301);
        check("t6_field_m", 24'(set_field), 24'd2);
        key_mode = 1'b1;
        RST = 1'b1;
        #1;
        check("t6_async_time", tm, 24'h000000);
        check("t6_async_field", 24'(set_field), 24'd0);
        step(1);
        key_mode = 1'b0;
        RST = 1'b0;
        step(1);
        check("t6_after_rst", tm, 24'h000000);
        check("t6_after_field", 24'(set_field), 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
